// File: rtl/lcd_pkg.sv
// Shared HD44780 command codes, FSM encodings and delay helpers.
// LCD_AUTOWRAP_EN adds the S_WRAP state used for automatic row wrap.
package lcd_pkg;

    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_HOME      = 8'h02;
    localparam logic [7:0] CMD_ENTRY     = 8'h06;
    localparam logic [7:0] CMD_DISP_OFF  = 8'h08;
    localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
    localparam logic [7:0] CMD_FSET_1L   = 8'h20;
    localparam logic [7:0] CMD_FSET_2L   = 8'h28;
    localparam logic [7:0] CMD_SET_DDRAM = 8'h80;

    typedef enum logic [2:0] {
        S_PWR_WAIT,
        S_INIT_NIB,
        S_INIT_CMD,
        S_IDLE,
        S_SEND
`ifdef LCD_AUTOWRAP_EN
        , S_WRAP
`endif
    } lcd_state_t;

    typedef enum logic [2:0] {
        P_IDLE,
        P_SETUP,
        P_HIGH,
        P_LOW,
        P_POST
    } tx_phase_t;

    function automatic longint unsigned ns_to_cyc(input longint unsigned freq,
                                                  input longint unsigned ns);
        return (freq * ns) / 64'd1_000_000_000;
    endfunction

    // A zero-length delay would stall the transmitter, so clamp to one cycle.
    function automatic int unsigned cyc_min1(input longint unsigned c);
        return (c == 64'd0) ? 32'd1 : 32'(c);
    endfunction

endpackage

// File: rtl/lcd_nibble_tx.sv
// Serialises one byte (two nibbles) or a single init nibble onto the 4-bit
// HD44780 bus, then holds off for the requested post-delay.
module lcd_nibble_tx
    import lcd_pkg::*;
#(
    parameter int unsigned EN_CYC = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic        rs,
    input  logic [7:0]  data,
    input  logic        nibble_only,
    input  logic [31:0] post_cyc,
    output logic        lcd_rs,
    output logic        lcd_en,
    output logic [3:0]  lcd_d,
    output logic        done
);

    tx_phase_t   phase;
    logic [31:0] cnt;
    logic [31:0] post_r;
    logic [3:0]  lo_r;
    logic        second;
    logic        nib_only_r;

    // Asserted during the last post-delay cycle so the caller can react on
    // the same edge that retires the transfer.
    assign done = (phase == P_POST) && (cnt == post_r - 32'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            phase      <= P_IDLE;
            cnt        <= '0;
            post_r     <= '0;
            lo_r       <= '0;
            second     <= 1'b0;
            nib_only_r <= 1'b0;
            lcd_rs     <= 1'b0;
            lcd_en     <= 1'b0;
            lcd_d      <= '0;
        end else begin
            case (phase)
                P_IDLE: begin
                    if (go) begin
                        lcd_rs     <= rs;
                        lcd_d      <= data[7:4];
                        lo_r       <= data[3:0];
                        post_r     <= post_cyc;
                        nib_only_r <= nibble_only;
                        second     <= 1'b0;
                        phase      <= P_SETUP;
                    end
                end
                P_SETUP: begin
                    lcd_en <= 1'b1;
                    cnt    <= '0;
                    phase  <= P_HIGH;
                end
                P_HIGH: begin
                    if (cnt == EN_CYC - 32'd1) begin
                        lcd_en <= 1'b0;
                        cnt    <= '0;
                        phase  <= P_LOW;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                P_LOW: begin
                    if (cnt == EN_CYC - 32'd1) begin
                        cnt <= '0;
                        if (!second && !nib_only_r) begin
                            second <= 1'b1;
                            lcd_d  <= lo_r;
                            phase  <= P_SETUP;
                        end else begin
                            phase <= P_POST;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                P_POST: begin
                    if (cnt == post_r - 32'd1) begin
                        cnt   <= '0;
                        phase <= P_IDLE;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: phase <= P_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/lcd_hd44780_stream.sv
// HD44780 4-bit controller: power-on init, then streams host bytes with cursor
// tracking. Define LCD_AUTOWRAP_EN to re-address the next row when a row fills.
module lcd_hd44780_stream
    import lcd_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned COLS        = 16,
    parameter int unsigned ROWS        = 2,
    parameter int unsigned EN_PULSE_NS = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_is_cmd,
    output logic       init_done,
    output logic [5:0] cursor_col,
    output logic       cursor_row,
    output logic       lcd_rs,
    output logic       lcd_en,
    output logic       lcd_rw,
    output logic [3:0] lcd_d
);

    localparam int unsigned EN_CYC = cyc_min1(ns_to_cyc(64'(CLK_FREQ_HZ), 64'(EN_PULSE_NS)) + 64'd1);
    localparam int unsigned D15M   = cyc_min1(ns_to_cyc(64'(CLK_FREQ_HZ), 64'd15_000_000));
    localparam int unsigned D4M1   = cyc_min1(ns_to_cyc(64'(CLK_FREQ_HZ), 64'd4_100_000));
    localparam int unsigned D100U  = cyc_min1(ns_to_cyc(64'(CLK_FREQ_HZ), 64'd100_000));
    localparam int unsigned D40U   = cyc_min1(ns_to_cyc(64'(CLK_FREQ_HZ), 64'd40_000));
    localparam int unsigned D1M6   = cyc_min1(ns_to_cyc(64'(CLK_FREQ_HZ), 64'd1_600_000));

    localparam logic [5:0] COL_LAST = 6'(COLS - 1);
    localparam logic [7:0] FSET     = (ROWS == 2) ? CMD_FSET_2L : CMD_FSET_1L;

    lcd_state_t  state;
    logic [31:0] wait_cnt;
    logic [2:0]  idx;
    logic        go;
    logic        tx_rs;
    logic        tx_nib;
    logic [7:0]  tx_data;
    logic [31:0] tx_post;
    logic        tx_done;
    logic [7:0]  cap_data;
    logic        cap_cmd;
`ifdef LCD_AUTOWRAP_EN
    logic        wrap_row;
`endif

    assign lcd_rw = 1'b0;

    function automatic logic [7:0] init_cmd(input logic [2:0] i);
        case (i)
            3'd0:    return FSET;
            3'd1:    return CMD_DISP_OFF;
            3'd2:    return CMD_CLEAR;
            3'd3:    return CMD_ENTRY;
            default: return CMD_DISP_ON;
        endcase
    endfunction

    function automatic logic [31:0] byte_post(input logic [7:0] b, input logic is_cmd);
        return (is_cmd && (b == 8'h01 || b == 8'h02 || b == 8'h03)) ? D1M6 : D40U;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_PWR_WAIT;
            wait_cnt   <= '0;
            idx        <= '0;
            go         <= 1'b0;
            tx_rs      <= 1'b0;
            tx_nib     <= 1'b0;
            tx_data    <= '0;
            tx_post    <= '0;
            cap_data   <= '0;
            cap_cmd    <= 1'b0;
            in_ready   <= 1'b0;
            init_done  <= 1'b0;
            cursor_col <= '0;
            cursor_row <= 1'b0;
`ifdef LCD_AUTOWRAP_EN
            wrap_row   <= 1'b0;
`endif
        end else begin
            go <= 1'b0;
            case (state)
                S_PWR_WAIT: begin
                    if (wait_cnt == D15M - 32'd1) begin
                        state   <= S_INIT_NIB;
                        idx     <= '0;
                        go      <= 1'b1;
                        tx_rs   <= 1'b0;
                        tx_nib  <= 1'b1;
                        tx_data <= 8'h30;
                        tx_post <= D4M1;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                S_INIT_NIB: begin
                    if (tx_done) begin
                        go    <= 1'b1;
                        tx_rs <= 1'b0;
                        if (idx == 3'd3) begin
                            state   <= S_INIT_CMD;
                            idx     <= '0;
                            tx_nib  <= 1'b0;
                            tx_data <= init_cmd(3'd0);
                            tx_post <= D40U;
                        end else begin
                            idx     <= idx + 3'd1;
                            tx_nib  <= 1'b1;
                            tx_data <= (idx == 3'd2) ? 8'h20 : 8'h30;
                            tx_post <= (idx == 3'd2) ? D40U : D100U;
                        end
                    end
                end
                S_INIT_CMD: begin
                    if (tx_done) begin
                        if (idx == 3'd4) begin
                            init_done  <= 1'b1;
                            cursor_col <= '0;
                            cursor_row <= 1'b0;
                            in_ready   <= 1'b1;
                            state      <= S_IDLE;
                        end else begin
                            idx     <= idx + 3'd1;
                            go      <= 1'b1;
                            tx_rs   <= 1'b0;
                            tx_nib  <= 1'b0;
                            tx_data <= init_cmd(idx + 3'd1);
                            tx_post <= (idx == 3'd1) ? D1M6 : D40U;
                        end
                    end
                end
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        cap_data <= in_data;
                        cap_cmd  <= in_is_cmd;
                        go       <= 1'b1;
                        tx_rs    <= ~in_is_cmd;
                        tx_nib   <= 1'b0;
                        tx_data  <= in_data;
                        tx_post  <= byte_post(in_data, in_is_cmd);
                        state    <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (tx_done) begin
                        state    <= S_IDLE;
                        in_ready <= 1'b1;
                        if (!cap_cmd) begin
`ifdef LCD_AUTOWRAP_EN
                            cursor_col <= cursor_col + 6'd1;
                            if (cursor_col == COL_LAST) begin
                                // Row full: hold the host off and re-address DDRAM.
                                state    <= S_WRAP;
                                in_ready <= 1'b0;
                                go       <= 1'b1;
                                tx_rs    <= 1'b0;
                                tx_nib   <= 1'b0;
                                tx_post  <= D40U;
                                tx_data  <= (ROWS == 2 && !cursor_row) ?
                                            (CMD_SET_DDRAM | 8'h40) : CMD_SET_DDRAM;
                                wrap_row <= (ROWS == 2) && !cursor_row;
                            end
`else
                            if (cursor_col != COL_LAST)
                                cursor_col <= cursor_col + 6'd1;
`endif
                        end else if (cap_data == 8'h01 || cap_data == 8'h02 || cap_data == 8'h03) begin
                            cursor_col <= '0;
                            cursor_row <= 1'b0;
                        end else if (cap_data[7]) begin
                            cursor_row <= (ROWS == 2) ? cap_data[6] : 1'b0;
                            cursor_col <= (32'(cap_data[5:0]) < COLS) ? cap_data[5:0] : 6'd0;
                        end
                    end
                end
`ifdef LCD_AUTOWRAP_EN
                S_WRAP: begin
                    if (tx_done) begin
                        cursor_col <= '0;
                        cursor_row <= wrap_row;
                        in_ready   <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
`endif
                default: state <= S_PWR_WAIT;
            endcase
        end
    end

    lcd_nibble_tx #(
        .EN_CYC(EN_CYC)
    ) u_tx (
        .clk         (clk),
        .rst         (rst),
        .go          (go),
        .rs          (tx_rs),
        .data        (tx_data),
        .nibble_only (tx_nib),
        .post_cyc    (tx_post),
        .lcd_rs      (lcd_rs),
        .lcd_en      (lcd_en),
        .lcd_d       (lcd_d),
        .done        (tx_done)
    );

endmodule

// File: tb/tb_lcd_hd44780_stream.sv
// Scoreboard bench: stimulus queues expected {RS,nibble} pairs, a monitor pops
// and compares them on every EN falling edge. Runs at 500 kHz so init is short.
module tb_lcd_hd44780_stream;

    // 500 kHz, 4 us EN: EN_CYC=3, D15M=7500, D40U=20, D1M6=800
    localparam int unsigned LAT_SHORT = 35;   // 1 + 2*(1+2*3) + 20
    localparam int unsigned LAT_LONG  = 815;  // 1 + 2*(1+2*3) + 800

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_is_cmd;
    logic       init_done;
    logic [5:0] cursor_col;
    logic       cursor_row;
    logic       lcd_rs, lcd_en, lcd_rw;
    logic [3:0] lcd_d;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [4:0]  exp_q[$];

    always #5 clk = ~clk;

    lcd_hd44780_stream #(
        .CLK_FREQ_HZ (500_000),
        .COLS        (16),
        .ROWS        (2),
        .EN_PULSE_NS (4000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_is_cmd  (in_is_cmd),
        .init_done  (init_done),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .lcd_rs     (lcd_rs),
        .lcd_en     (lcd_en),
        .lcd_rw     (lcd_rw),
        .lcd_d      (lcd_d)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void push_byte(input logic [7:0] b, input logic rs);
        exp_q.push_back({rs, b[7:4]});
        exp_q.push_back({rs, b[3:0]});
    endfunction

    function automatic void push_init();
        exp_q.push_back(5'h03);
        exp_q.push_back(5'h03);
        exp_q.push_back(5'h03);
        exp_q.push_back(5'h02);
        push_byte(8'h28, 1'b0);
        push_byte(8'h08, 1'b0);
        push_byte(8'h01, 1'b0);
        push_byte(8'h06, 1'b0);
        push_byte(8'h0C, 1'b0);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_init();
        int unsigned n = 0;
        while (!init_done && n < 20000) begin
            step();
            n++;
        end
        chk("init_done", init_done, 1);
        chk("init_min_cycles", 32'(n >= 7500), 1);
        chk("init_in_ready", in_ready, 1);
        chk("init_cursor", {cursor_row, cursor_col}, 0);
        chk("init_queue_drained", exp_q.size(), 0);
    endtask

    task automatic wait_ready();
        int unsigned n = 0;
        while (!in_ready && n < 2000) begin
            step();
            n++;
        end
        chk("in_ready_wait", in_ready, 1);
    endtask

    task automatic send(input logic [7:0] b, input logic is_cmd, input int unsigned exp_lat,
                        input bit chk_lat, input bit wrap_exp);
        int unsigned n = 0;
        if (!in_ready) wait_ready();
        push_byte(b, ~is_cmd);
        if (wrap_exp) push_byte(8'hC0, 1'b0);
        in_valid  = 1'b1;
        in_data   = b;
        in_is_cmd = is_cmd;
        step();
        in_valid = 1'b0;
        while (!in_ready && n < 2000) begin
            step();
            n++;
        end
        chk($sformatf("ready_after_%02h", b), in_ready, 1);
        if (chk_lat) chk($sformatf("latency_%02h", b), n, exp_lat);
    endtask

    // Monitor: every EN fall (outside reset) presents one nibble.
    initial begin
        logic       en_prev;
        logic       rst_prev;
        logic [4:0] e;
        en_prev  = 1'b0;
        rst_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (en_prev && !lcd_en && !rst_prev) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_nibble", {27'b0, lcd_rs, lcd_d}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("nibble", {27'b0, lcd_rs, lcd_d}, {27'b0, e});
                end
                chk("lcd_rw", lcd_rw, 0);
            end
            en_prev  = lcd_en;
            rst_prev = rst;
        end
    end

    initial begin
        bit autowrap;
        int unsigned n;
`ifdef LCD_AUTOWRAP_EN
        autowrap = 1'b1;
`else
        autowrap = 1'b0;
`endif
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_is_cmd = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {in_ready, init_done, lcd_rs, lcd_en, lcd_rw, lcd_d, cursor_row, cursor_col}, 0);

        push_init();
        rst = 1'b0;
        wait_init();

        send(8'h41, 1'b0, LAT_SHORT, 1'b1, 1'b0);
        chk("cursor_after_41", {cursor_row, cursor_col}, {1'b0, 6'd1});
        send(8'hC5, 1'b1, LAT_SHORT, 1'b1, 1'b0);
        chk("cursor_after_C5", {cursor_row, cursor_col}, {1'b1, 6'd5});
        send(8'h94, 1'b1, LAT_SHORT, 1'b1, 1'b0);
        chk("cursor_col_oob", {cursor_row, cursor_col}, {1'b0, 6'd0});
        send(8'h83, 1'b1, LAT_SHORT, 1'b1, 1'b0);
        send(8'h0C, 1'b1, LAT_SHORT, 1'b1, 1'b0);
        chk("cursor_plain_cmd", {cursor_row, cursor_col}, {1'b0, 6'd3});
        send(8'h02, 1'b1, LAT_LONG, 1'b1, 1'b0);
        chk("cursor_after_home", {cursor_row, cursor_col}, 0);
        send(8'hCA, 1'b1, LAT_SHORT, 1'b1, 1'b0);
        send(8'h01, 1'b1, LAT_LONG, 1'b1, 1'b0);
        chk("cursor_after_clear", {cursor_row, cursor_col}, 0);

        for (int i = 0; i < 16; i++) begin
            if (i == 15 && autowrap)
                send(8'(8'h30 + i), 1'b0, 2 * LAT_SHORT, 1'b1, 1'b1);
            else
                send(8'(8'h30 + i), 1'b0, LAT_SHORT, 1'b1, 1'b0);
        end
        chk("row_fill_cursor", {cursor_row, cursor_col}, autowrap ? {1'b1, 6'd0} : {1'b0, 6'd15});
        chk("row_fill_queue", exp_q.size(), 0);

        // in_valid held through busy time with changing junk data
        push_byte(8'h61, 1'b1);
        in_valid  = 1'b1;
        in_data   = 8'h61;
        in_is_cmd = 1'b0;
        step();
        n = 0;
        while (!in_ready && n < 2000) begin
            in_data   = 8'(8'h90 + n);
            in_is_cmd = n[0];
            step();
            n++;
        end
        chk("hold_ready", in_ready, 1);
        push_byte(8'h5A, 1'b1);
        in_data   = 8'h5A;
        in_is_cmd = 1'b0;
        step();
        in_valid = 1'b0;
        wait_ready();
        chk("hold_queue", exp_q.size(), 0);
        chk("hold_cursor", {cursor_row, cursor_col}, autowrap ? {1'b1, 6'd2} : {1'b0, 6'd15});

        // reset during EN high of a data byte
        push_byte(8'h77, 1'b1);
        in_valid  = 1'b1;
        in_data   = 8'h77;
        in_is_cmd = 1'b0;
        step();
        in_valid = 1'b0;
        n = 0;
        while (!lcd_en && n < 100) begin
            step();
            n++;
        end
        chk("en_high_before_rst", lcd_en, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_en", lcd_en, 0);
        chk("mid_rst_ready", in_ready, 0);
        chk("mid_rst_init_done", init_done, 0);
        chk("mid_rst_cursor", {cursor_row, cursor_col}, 0);
        exp_q.delete();
        push_init();
        wait_init();

        send(8'h42, 1'b0, LAT_SHORT, 1'b1, 1'b0);
        chk("cursor_after_restart", {cursor_row, cursor_col}, {1'b0, 6'd1});
        chk("final_queue", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
